// File: rtl/serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_arbiter
// Purpose  : Round-robin arbiter sharing one bit-serial full-adder cell
//            between two requesters. A granted operand pair is rippled
//            LSB-first through the cell over W cycles, after which the sum
//            and carry-out are published with a one-cycle done pulse.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req0_i/a0_i/b0_i    - requester 0 request (level) and operands
//            req1_i/a1_i/b1_i    - requester 1 request (level) and operands
//            gnt_o[1:0]          - one-hot registered grant pulse
//            busy_o              - operation in flight (RUN or DONE)
//            sum_o/cout_o        - result of the last completed operation
//            done_o              - one-cycle result-valid pulse
//            done_id_o           - requester index of the result held
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] b0_i,
  input  logic         req1_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b1_i,
  output logic [1:0]   gnt_o,
  output logic         busy_o,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         done_o,
  output logic         done_id_o
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  res_q, res_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          id_q, id_d;
  logic          last_q, last_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          done_id_q, done_id_d;
  logic          win;

  // Full adder as two cascaded half adders on the current LSBs and carry.
  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nxt;
  assign ha1_s     = sa_q[0] ^ sb_q[0];
  assign ha1_c     = sa_q[0] & sb_q[0];
  assign ha2_s     = ha1_s ^ c_q;
  assign ha2_c     = ha1_s & c_q;
  assign carry_nxt = ha1_c | ha2_c;

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    res_d     = res_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    gnt_d     = 2'b00;
    id_d      = id_q;
    last_d    = last_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    done_id_d = done_id_q;
    win       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie the requester not served last wins; otherwise the
          // sole requester wins.
          win       = (req0_i && req1_i) ? ~last_q : req1_i;
          sa_d      = win ? a1_i : a0_i;
          sb_d      = win ? b1_i : b0_i;
          c_d       = 1'b0;
          cnt_d     = '0;
          gnt_d     = win ? 2'b10 : 2'b01;
          id_d      = win;
          last_d    = win;
          state_d   = RUN;
        end
      end
      RUN: begin
        res_d = {ha2_s, res_q[W-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = carry_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the result including the bit produced on this edge.
          sum_d     = {ha2_s, res_q[W-1:1]};
          cout_d    = carry_nxt;
          done_id_d = id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= 2'b00;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      res_q     <= res_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign done_id_o = done_id_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_arbiter
// Purpose  : Scoreboard bench for serial_add_arbiter. Stimulus pushes the
//            hand-computed result of each operation; a monitor pops and
//            compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]   gnt_o;
  logic         busy_o, cout_o, done_o, done_id_o;
  logic [W-1:0] sum_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t exp_q[$];

  serial_add_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (req0),
    .a0_i      (a0),
    .b0_i      (b0),
    .req1_i    (req1),
    .a1_i      (a1),
    .b1_i      (b1),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .sum_o     (sum_o),
    .cout_o    (cout_o),
    .done_o    (done_o),
    .done_id_o (done_id_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin : mon_done
    exp_t e;
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_id=%0d sum=%0d, expected no result",
                 done_id_o, sum_o);
      end else begin
        e = exp_q.pop_front();
        chk("done_id", done_id_o, e.id);
        chk("sum", sum_o, e.sum);
        chk("cout", cout_o, e.cout);
      end
    end
  end

  // Grant monitor: one-hot, never in consecutive cycles, busy alongside.
  logic [1:0] gnt_prev = 2'b00;
  always @(negedge clk) begin
    if (gnt_o != 2'b00) begin
      chk("gnt_onehot", {31'd0, $onehot(gnt_o)}, 1);
      chk("gnt_no_repeat", gnt_prev, 0);
      chk("gnt_busy", busy_o, 1);
    end
    gnt_prev = gnt_o;
  end

  task automatic wait_gnt(input int n, output int t);
    int k = 0;
    while (!gnt_o[n] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!gnt_o[n]) begin
      checks++;
      errors++;
      $display("FAIL gnt%0d_timeout: got no grant, expected one within 40 cycles", n);
    end
    t = cyc;
  endtask

  task automatic wait_done(output int t);
    int k = 0;
    while (!done_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected one within 40 cycles");
    end
    t = cyc;
  endtask

  task automatic set_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin req0 = v; a0 = a; b0 = b; end
    else         begin req1 = v; a1 = a; b1 = b; end
  endtask

  // One isolated operation from IDLE: checks grant latency, grant value,
  // done latency; operands are scrambled after grant to prove latching.
  task automatic run_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec);
    int t0, tg, td;
    @(negedge clk);
    set_req(id, 1'b1, a, b);
    exp_q.push_back('{id: id[0], sum: es, cout: ec});
    t0 = cyc;
    wait_gnt(id, tg);
    chk("grant_latency", tg - t0, 1);
    chk("gnt_value", gnt_o, (id == 0) ? 2 'b01 : 2'b10);
    set_req(id, 1'b0, ~a, ~b);
    wait_done(td);
    chk("done_latency", td - tg, W);
  endtask

  initial begin : stim
    int t1, t2, tp, td0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sum", sum_o, 0);
    rst = 1'b0;

    // Single add and overflow cases.
    run_one(0, 8'd3, 8'd5, 8'd8, 1'b0);
    run_one(1, 8'd255, 8'd1, 8'd0, 1'b1);
    run_one(1, 8'd200, 8'd100, 8'd44, 1'b1);

    // Tie: req0 wins after its last loss, each drops on its own grant.
    // last is 1 here (requester 1 served most recently).
    @(negedge clk);
    set_req(0, 1'b1, 8'd10, 8'd20);
    set_req(1, 1'b1, 8'd7, 8'd9);
    exp_q.push_back('{id: 1'b0, sum: 8'd30, cout: 1'b0});
    exp_q.push_back('{id: 1'b1, sum: 8'd16, cout: 1'b0});
    wait_gnt(0, t1);
    req0 = 1'b0;
    wait_gnt(1, t2);
    req1 = 1'b0;
    chk("tie_period", t2 - t1, W + 2);
    wait_done(td0);
    @(negedge clk);

    // Fairness: both held high for four operations.
    set_req(0, 1'b1, 8'd100, 8'd27);
    set_req(1, 1'b1, 8'd128, 8'd128);
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{id: i[0], sum: (i[0] ? 8'd0 : 8'd127), cout: i[0]});
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(i % 2, t1);
      if (i > 0) chk("fair_period", t1 - tp, W + 2);
      tp = t1;
      if (i < 3) @(negedge clk);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(td0);
    @(negedge clk);

    // Late request: req1 arrives mid-RUN and must wait for IDLE.
    set_req(0, 1'b1, 8'd50, 8'd60);
    exp_q.push_back('{id: 1'b0, sum: 8'd110, cout: 1'b0});
    wait_gnt(0, t1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    set_req(1, 1'b1, 8'd9, 8'd9);
    exp_q.push_back('{id: 1'b1, sum: 8'd18, cout: 1'b0});
    wait_done(td0);
    chk("late_no_early_gnt", gnt_o, 0);
    wait_gnt(1, t2);
    req1 = 1'b0;
    chk("late_gnt_gap", t2 - td0, 2);
    wait_done(td0);
    @(negedge clk);

    // Reset at cnt=3 of an operation: outputs clear, no done pulse.
    set_req(0, 1'b1, 8'd200, 8'd55);
    wait_gnt(0, t1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", gnt_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_sum", sum_o, 0);
    chk("midrst_cout", cout_o, 0);
    chk("midrst_done_id", done_id_o, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_one(0, 8'd1, 8'd1, 8'd2, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Shares one bit-serial adder cell between two requesters. The cell is a full adder built from two half-adder stages plus a carry flip-flop. Each grant latches a pair of W-bit operands and ripples them LSB-first through the cell over W cycles. It then presents the W-bit sum and carry-out with a one-cycle done pulse tagged with the served requester. The block sits between client logic and the arithmetic datapath, and it is the only path by which clients reach the shared adder.

## Interface
- W, default 8, operand/sum width (≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req0  in  1  requester 0 request, level
- a0, b0  in  W each  requester 0 operands, held stable while req0=1
- req1  in  1  requester 1 request, level
- a1, b1  in  W each  requester 1 operands, held stable while req1=1
- gnt  out  2  one-hot grant pulse (bit n = requester n), registered
- busy  out  1  high whenever FSM ≠ IDLE
- sum  out  W  result of last completed operation
- cout  out  1  carry-out of last completed operation
- done  out  1  one-cycle result-valid pulse
- done_id  out  1  requester index of the result on sum/cout

Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE** samples req0/req1 at each edge.
  - With no request, it stays in IDLE.
  - With a request, it selects a winner, latches that requester's a/b into shift registers sa/sb, clears the carry flop, clears bit counter cnt, registers gnt[winner]=1, records id=winner, and goes to RUN.
- **Arbitration** is round-robin with pointer last (the last requester served).
  - A single request wins.
  - When both request, the requester ≠ last wins.
  - After reset, last=1, so req0 wins the first tie.
  - last updates to the winner at grant.
- **RUN**, each edge:
  - s_bit = sa[0]^sb[0]^c, computed as two cascaded half-adder stages.
  - c ← (sa[0]&sb[0]) | ((sa[0]^sb[0])&c).
  - s_bit shifts into the MSB of the result shift register; sa and sb shift right; cnt increments.
  - At the edge where cnt=W-1, the FSM goes to DONE.
- **DONE** lasts one cycle.
  - The edge entering DONE loads sum ← the full result register, cout ← final carry, and done_id ← id.
  - done=1 for exactly this cycle.
  - The next edge returns the FSM to IDLE unconditionally.
- **Request rules:**
  - Requests are sampled only in IDLE. A req asserted during RUN or DONE waits.
  - A req still high after its gnt is treated as a new request and is re-arbitrated against the other requester. The requester must drop req in the cycle gnt is seen to avoid a repeat.
- **Arithmetic:** sum = (a+b) mod 2^W, and cout = bit W of a+b. Operands are unsigned.
- **Output holding:** sum, cout and done_id hold their values until the next DONE entry. Operand changes after grant have no effect.
- **Reset** in any state, including mid-RUN:
  - Next state is IDLE. Any in-flight operation is discarded with no done pulse.
  - gnt=0, busy=0, done=0, sum=0, cout=0, done_id=0, cnt=0, carry=0, last=1.

## Timing
- Edge E0: IDLE samples req. gnt is high in the cycle after E0, and busy rises at the same time.
- Edges E1..EW process bits 0..W-1.
- EW enters DONE, so done is high in the cycle after EW. That is W+1 cycles after the sampling edge.
- Back-to-back service: the DONE→IDLE edge is followed by a grant at the next edge. Per-operation period is W+2 cycles.
- gnt is a one-cycle pulse and is never high in two consecutive cycles.
- busy is high from the cycle after E0 through the done cycle, inclusive.

## Test plan
- **Single add:** W=8, req0 with a0=3, b0=5.
  - Expect gnt=01 for 1 cycle.
  - Expect done at the 9th cycle after the sampling edge, with sum=8, cout=0, done_id=0.
- **Overflow:** req1 with a1=255, b1=1 → sum=0, cout=1, done_id=1. Then a1=200, b1=100 → sum=44, cout=1.
- **Tie after reset:** req0 and req1 both high, operands 10+20 and 7+9, each requester dropping req on its own gnt.
  - Expect req0 served first (sum=30), then req1 (sum=16).
  - The second gnt comes exactly W+2 cycles after the first.
- **Fairness:** both reqs held high continuously for 4 operations → done_id sequence 0,1,0,1 with no skipped grant.
- **Late request:** req1 asserted mid-RUN of a req0 operation → no gnt until after the DONE cycle; the req1 result is correct.
- **Reset mid-RUN:** assert rst at cnt=3.
  - Expect the next cycle to show all outputs at their reset values and no done pulse.
  - A fresh req0 of 1+1 then yields sum=2 after W+1 cycles.
